// File: rtl/spi_pkg.sv
// Constants shared by the SPI master, slave and receive buffer.
package spi_pkg;

  localparam int DW_DEFAULT    = 8;
  localparam int DEPTH_DEFAULT = 8;
  localparam int DROP_CNT_W    = 8;

  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

  // Saturating increment for the dropped-byte counter.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == DROP_CNT_MAX) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/spi_rx_buffer_if.sv
// Byte-in / show-ahead read / status bundle of the SPI receive buffer.
interface spi_rx_buffer_if #(
  parameter int DW    = spi_pkg::DW_DEFAULT,
  parameter int DEPTH = spi_pkg::DEPTH_DEFAULT
) ();

  logic                          done;
  logic [DW-1:0]                 din;
  logic                          rd_ready;
  logic                          rd_valid;
  logic [DW-1:0]                 rd_data;
  logic [$clog2(DEPTH):0]        count;
  logic                          full;
  logic                          empty;
  logic                          overflow;
  logic                          clr_ovf;
  logic [spi_pkg::DROP_CNT_W-1:0] drop_cnt;

  // slave is the buffer itself; master is the SPI slave stage plus consumer.
  modport slave (
    input  done, din, rd_ready, clr_ovf,
    output rd_valid, rd_data, count, full, empty, overflow, drop_cnt
  );

  modport master (
    output done, din, rd_ready, clr_ovf,
    input  rd_valid, rd_data, count, full, empty, overflow, drop_cnt
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop single-bit synchronizer with asynchronous reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_rx_buffer.sv
// Show-ahead FIFO capturing bytes from the SPI slave stage on each
// synchronized rising edge of its asynchronous done flag.
module spi_rx_buffer
  import spi_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int DW    = DW_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  spi_rx_buffer_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0]            mem [DEPTH];
  logic [AW-1:0]            wptr;
  logic [AW-1:0]            rptr;
  logic [CW-1:0]            count_q;
  logic                     done_s;
  logic                     done_q;
  logic                     push;
  logic                     pop;
  logic                     is_full;
  logic                     wr_en;
  logic                     drop;
  logic                     overflow_q;
  logic [DROP_CNT_W-1:0]    drop_q;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.done),
    .q   (done_s)
  );

  // A pop frees a slot in the same cycle, so a push into a full buffer
  // is only dropped when nothing is being read out.
  assign is_full = (count_q == CW'(DEPTH));
  assign push    = done_s & ~done_q;
  assign pop     = (count_q != '0) && bus.rd_ready;
  assign wr_en   = push && (!is_full || pop);
  assign drop    = push && is_full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q  <= 1'b0;
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
    end else begin
      done_q <= done_s;
      if (wr_en) wptr <= wptr + AW'(1);
      if (pop)   rptr <= rptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // A drop landing on the clear cycle survives as the first new drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else if (bus.clr_ovf) begin
      overflow_q <= drop;
      drop_q     <= drop ? DROP_CNT_W'(1) : '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      drop_q     <= sat_inc(drop_q);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= bus.din;
  end

  assign bus.rd_valid = (count_q != '0);
  assign bus.rd_data  = mem[rptr];
  assign bus.count    = count_q;
  assign bus.full     = is_full;
  assign bus.empty    = (count_q == '0);
  assign bus.overflow = overflow_q;
  assign bus.drop_cnt = drop_q;

endmodule
